// File: rtl/dmem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_rr_arbiter
//
// Shares one single-ported DRAM between four cores. Each core presents a
// level-sensitive read or write request that it holds until it sees a
// one-cycle completion pulse. The arbiter serves one transaction at a time
// and picks the next port round-robin, starting just after the port that was
// served last. A port that has been served is locked out until it drops its
// request (four-phase handshake), so a core that keeps its request high
// cannot be served twice for the same request.
//
// Transaction timing, counting the IDLE cycle in which the grant happens as T:
//   read : rEN at T+1, DRAM data on MEM at T+2, MEM_k and memAV_k at T+3
//   write: wEN at T+1, memAV_k at T+2
//
// Ports
//   Clk, Rst_n            clock, asynchronous active-low reset
//   coreS_k               core k halted; its requests are ignored while high
//   memREAD_k / memWE_k   core k read / write request (write wins if both)
//   AR_k / DR_k           core k address / write data
//   MEM_k                 registered read data returned to core k
//   memAV_k               registered one-cycle completion pulse to core k
//   addr / DR_OUT         DRAM address / write data (hold outside ISSUE)
//   rEN / wEN             DRAM read / write enable (high only in ISSUE)
//   MEM                   DRAM read data, valid one cycle after rEN
// -----------------------------------------------------------------------------
module dmem_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,

    input  logic             coreS_1,
    input  logic             coreS_2,
    input  logic             coreS_3,
    input  logic             coreS_4,

    input  logic             memREAD_1,
    input  logic             memREAD_2,
    input  logic             memREAD_3,
    input  logic             memREAD_4,

    input  logic             memWE_1,
    input  logic             memWE_2,
    input  logic             memWE_3,
    input  logic             memWE_4,

    input  logic [WIDTH-1:0] AR_1,
    input  logic [WIDTH-1:0] AR_2,
    input  logic [WIDTH-1:0] AR_3,
    input  logic [WIDTH-1:0] AR_4,

    input  logic [WIDTH-1:0] DR_1,
    input  logic [WIDTH-1:0] DR_2,
    input  logic [WIDTH-1:0] DR_3,
    input  logic [WIDTH-1:0] DR_4,

    output logic [WIDTH-1:0] MEM_1,
    output logic [WIDTH-1:0] MEM_2,
    output logic [WIDTH-1:0] MEM_3,
    output logic [WIDTH-1:0] MEM_4,

    output logic             memAV_1,
    output logic             memAV_2,
    output logic             memAV_3,
    output logic             memAV_4,

    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] DR_OUT,
    output logic             rEN,
    output logic             wEN,
    input  logic [WIDTH-1:0] MEM
);

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;  // waiting for an eligible port
    localparam logic [1:0] S_ISSUE = 2'd1;  // rEN or wEN on the DRAM bus
    localparam logic [1:0] S_CAPT  = 2'd2;  // DRAM read data on MEM
    localparam logic [1:0] S_DONE  = 2'd3;  // memAV pulse to the granted port

    // -------------------------------------------------------------------------
    // Per-port inputs gathered into vectors/arrays so the grant logic can
    // index them by port number (index 0 is core 1).
    // -------------------------------------------------------------------------
    logic [3:0]       halt;
    logic [3:0]       rd_req;
    logic [3:0]       wr_req;
    logic [WIDTH-1:0] ar [4];
    logic [WIDTH-1:0] dr [4];

    assign halt   = {coreS_4,   coreS_3,   coreS_2,   coreS_1};
    assign rd_req = {memREAD_4, memREAD_3, memREAD_2, memREAD_1};
    assign wr_req = {memWE_4,   memWE_3,   memWE_2,   memWE_1};

    assign ar[0] = AR_1;
    assign ar[1] = AR_2;
    assign ar[2] = AR_3;
    assign ar[3] = AR_4;

    assign dr[0] = DR_1;
    assign dr[1] = DR_2;
    assign dr[2] = DR_3;
    assign dr[3] = DR_4;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;   // first port to look at in IDLE
    logic [1:0]       gnt_q,    gnt_d;      // port owning the transaction
    logic             is_wr_q,  is_wr_d;    // latched operation
    logic [3:0]       served_q, served_d;   // handshake lock-out per port
    logic [WIDTH-1:0] addr_q,   addr_d;
    logic [WIDTH-1:0] dout_q,   dout_d;
    logic             ren_q,    ren_d;
    logic             wen_q,    wen_d;
    logic [3:0]       av_q,     av_d;
    logic [WIDTH-1:0] rdata_q [4];
    logic [WIDTH-1:0] rdata_d [4];

    // -------------------------------------------------------------------------
    // Eligibility and round-robin selection
    // -------------------------------------------------------------------------
    logic [3:0] eligible;
    logic       gnt_found;
    logic [1:0] gnt_idx;

    assign eligible = (rd_req | wr_req) & ~halt & ~served_q;

    // Scan the four ports starting at rr_ptr; the 2-bit index wraps 4->1 on
    // its own, so the first hit in scan order is the round-robin winner.
    always_comb begin
        logic [1:0] idx;
        // NOTE: every signal written in an always_comb gets a default value
        // first; a path that leaves one unassigned would infer a latch.
        idx       = '0;
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!gnt_found && eligible[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        ren_d    = 1'b0;
        wen_d    = 1'b0;
        av_d     = '0;
        rdata_d  = rdata_q;

        // A served port is released once it has dropped both request lines.
        served_d = served_q & (rd_req | wr_req);

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    // Address, data and operation are captured here so later
                    // changes on AR_k/DR_k/coreS_k cannot disturb the
                    // transaction. Write takes precedence over read.
                    gnt_d   = gnt_idx;
                    is_wr_d = wr_req[gnt_idx];
                    addr_d  = ar[gnt_idx];
                    dout_d  = dr[gnt_idx];
                    wen_d   = wr_req[gnt_idx];
                    ren_d   = ~wr_req[gnt_idx];
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (is_wr_q) begin
                    // Write completes as soon as the DRAM has taken it.
                    av_d[gnt_q] = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d     = S_CAPT;
                end
            end

            S_CAPT: begin
                // DRAM output is valid now, one cycle after rEN.
                rdata_d[gnt_q] = MEM;
                av_d[gnt_q]    = 1'b1;
                state_d        = S_DONE;
            end

            S_DONE: begin
                served_d[gnt_q] = 1'b1;
                rr_ptr_d        = gnt_q + 2'd1;
                state_d         = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            // NOTE: state uses non-blocking assignments so every register
            // samples the pre-edge values, independent of statement order.
            state_q  <= S_IDLE;
            rr_ptr_q <= 2'd0;
            gnt_q    <= 2'd0;
            is_wr_q  <= 1'b0;
            served_q <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            av_q     <= '0;
            // NOTE: the read-data holding registers are cleared because the
            // MEM_k outputs must read 0 in reset; a real RAM array would not
            // be reset.
            for (int k = 0; k < 4; k++) begin
                rdata_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            is_wr_q  <= is_wr_d;
            served_q <= served_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            av_q     <= av_d;
            for (int k = 0; k < 4; k++) begin
                rdata_q[k] <= rdata_d[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign addr    = addr_q;
    assign DR_OUT  = dout_q;
    assign rEN     = ren_q;
    assign wEN     = wen_q;

    assign MEM_1   = rdata_q[0];
    assign MEM_2   = rdata_q[1];
    assign MEM_3   = rdata_q[2];
    assign MEM_4   = rdata_q[3];

    assign memAV_1 = av_q[0];
    assign memAV_2 = av_q[1];
    assign memAV_3 = av_q[2];
    assign memAV_4 = av_q[3];

endmodule

// File: doc/dmem_rr_arbiter.md
DMEM_RR_ARBITER -- requirements
Module: dmem_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data and address width of all ports.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 coreS_k (k=1..4)  input  1 each  core k halted; while high, port k requests are ignored.
REQ-005 memREAD_k (k=1..4)  input  1 each  core k read request, level, held until served.
REQ-006 memWE_k (k=1..4)  input  1 each  core k write request, level, held until served.
REQ-007 AR_k (k=1..4)  input  WIDTH each  core k address, stable while its request is high.
REQ-008 DR_k (k=1..4)  input  WIDTH each  core k write data, stable while memWE_k is high.
REQ-009 MEM_k (k=1..4)  output  WIDTH each  read data returned to core k, registered.
REQ-010 memAV_k (k=1..4)  output  1 each  one-cycle completion pulse to core k, registered.
REQ-011 addr  output  WIDTH  DRAM address.
REQ-012 DR_OUT  output  WIDTH  DRAM write data.
REQ-013 rEN  output  1  DRAM read enable; DRAM returns data on MEM one cycle later.
REQ-014 wEN  output  1  DRAM write enable.
REQ-015 MEM  input  WIDTH  DRAM read data.

Function
REQ-016 Port k is eligible when memREAD_k or memWE_k is high, coreS_k is low and served_k is clear.
REQ-017 served_k sets in the DONE cycle for port k and clears once memREAD_k and memWE_k are both low, enforcing a four-phase handshake.
REQ-018 FSM states: IDLE, ISSUE, CAPT, DONE; one transaction is in flight at a time.
REQ-019 In IDLE, if any port is eligible, grant goes to the first eligible port scanning from rr_ptr upward with wrap 4->1, then the FSM moves to ISSUE; otherwise the FSM stays in IDLE.
REQ-020 At grant, latch the port index, AR_k, DR_k and the operation; memWE_k high makes it a write even if memREAD_k is also high.
REQ-021 ISSUE drives addr and DR_OUT with the latched values and asserts wEN for a write or rEN for a read, for exactly one cycle; then writes go to DONE and reads go to CAPT.
REQ-022 CAPT registers MEM into MEM_k of the granted port, then moves to DONE; MEM_j for every j != k holds its value.
REQ-023 DONE asserts only memAV_k of the granted port for one cycle, sets served_k, sets rr_ptr to k+1 (wrapping 4->1), then returns to IDLE.
REQ-024 Latency from the first IDLE cycle with the request eligible to memAV_k high: read 3 cycles, write 2 cycles.
REQ-025 rEN and wEN are never high together; both are low outside ISSUE.
REQ-026 addr and DR_OUT hold their last driven values outside ISSUE.
REQ-027 A port whose coreS_k rises after grant completes its transaction normally.
REQ-028 AR_k and DR_k changes after grant do not affect the in-flight transaction.

Reset
REQ-029 When Rst_n is low, the block SHALL asynchronously set: state IDLE, rr_ptr to port 1, all served_k clear, and MEM_k, memAV_k, addr, DR_OUT, rEN and wEN all 0.
REQ-030 Reset asserted mid-transaction SHALL abort it: wEN and rEN drop immediately, no memAV pulse is issued, and arbitration restarts from port 1 after release.
REQ-031 After Rst_n deasserts, the first grant may occur in the first rising edge at which Rst_n is high.

Verification
REQ-032 Single read: port 2 read at AR_2=0x80 with DRAM[0x80]=0x5A -> rEN at T+1 with addr=0x80, MEM_2=0x5A and memAV_2 high at T+3, other MEM_j unchanged.
REQ-033 Single write: port 3 write AR_3=0xC1, DR_3=0x33 -> wEN at T+1 with addr=0xC1 and DR_OUT=0x33, memAV_3 at T+2, then a readback returns 0x33.
REQ-034 Round-robin: all four ports request continuously and drop each request one cycle after their memAV -> service order 1,2,3,4, then a second round also 1,2,3,4 with no port served twice in a row.
REQ-035 Handshake: port 1 holds memREAD_1 high for 5 cycles after its memAV_1 -> no second grant to port 1 until memREAD_1 falls and rises again.
REQ-036 Combined and halted ports: port 4 asserts memREAD_4 and memWE_4 together -> treated as a write; port 1 requests with coreS_1=1 -> never granted.
REQ-037 Reset mid-write: Rst_n driven low during ISSUE -> wEN=0 within the same cycle, no memAV pulse, and all outputs 0.
